// File: rtl/mips_cpu_lsu_if.sv
// Request/response and Avalon-MM signals of the load/store unit.
// master: the LSU itself; slave: the CPU plus the memory it talks to.
interface mips_cpu_lsu_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_rt_old;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest;
   logic [31:0]       avm_readdata;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, req_rt_old, avm_waitrequest, avm_readdata,
      output req_ready, resp_valid, resp_data, resp_err, avm_address, avm_read, avm_write,
             avm_writedata, avm_byteenable
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, req_rt_old, avm_waitrequest, avm_readdata,
      input  req_ready, resp_valid, resp_data, resp_err, avm_address, avm_read, avm_write,
             avm_writedata, avm_byteenable
   );
endinterface

// File: rtl/mips_cpu_lsu.sv
// Multicycle MIPS load/store unit: one request at a time onto an Avalon-MM master,
// with lane steering, sign/zero extension, LWL/LWR merge and optional stall timeout.
module mips_cpu_lsu #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input logic            clk,
   input logic            rst,
   mips_cpu_lsu_if.master bus_if
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e            r_state, w_state;
   logic [3:0]        r_op, w_op;
   logic [1:0]        r_a, w_a;
   logic [31:0]       r_rt_old, w_rt_old;
   logic [31:0]       r_cnt, w_cnt;
   logic [31:0]       r_resp_data, w_resp_data;
   logic              r_resp_err, w_resp_err;
   logic [ADDR_W-1:0] r_avm_address, w_avm_address;
   logic              r_avm_read, w_avm_read;
   logic              r_avm_write, w_avm_write;
   logic [31:0]       r_avm_writedata, w_avm_writedata;
   logic [3:0]        r_avm_byteenable, w_avm_byteenable;

   function automatic logic f_req_err(input logic [3:0] op, input logic [1:0] a);
      logic err;
      case (op)
         4'd0, 4'd1, 4'd8:  err = 1'b0;
         4'd2, 4'd3, 4'd9:  err = a[0];
         4'd4, 4'd10:       err = (a != 2'b00);
         4'd5, 4'd6:        err = 1'b0;
         default:           err = 1'b1;
      endcase
      return err;
   endfunction

   function automatic logic [3:0] f_be(input logic [3:0] op, input logic [1:0] a);
      logic [3:0] be;
      case (op)
         4'd0, 4'd1, 4'd8: be = 4'b0001 << a;
         4'd2, 4'd3, 4'd9: be = a[1] ? 4'b1100 : 4'b0011;
         default:          be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] wd);
      logic [31:0] d;
      case (op)
         4'd8:    d = {4{wd[7:0]}};
         4'd9:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] f_load(input logic [3:0] op, input logic [1:0] a,
                                          input logic [31:0] rd, input logic [31:0] rt);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] d;
      b = rd[{a, 3'b000} +: 8];
      h = a[1] ? rd[31:16] : rd[15:0];
      case (op)
         4'd0: d = {{24{b[7]}}, b};
         4'd1: d = {24'd0, b};
         4'd2: d = {{16{h[15]}}, h};
         4'd3: d = {16'd0, h};
         4'd4: d = rd;
         4'd5: begin
            case (a)
               2'd0:    d = {rd[7:0], rt[23:0]};
               2'd1:    d = {rd[15:0], rt[15:0]};
               2'd2:    d = {rd[23:0], rt[7:0]};
               default: d = rd;
            endcase
         end
         4'd6: begin
            case (a)
               2'd0:    d = rd;
               2'd1:    d = {rt[31:24], rd[31:8]};
               2'd2:    d = {rt[31:16], rd[31:16]};
               default: d = {rt[31:8], rd[31:24]};
            endcase
         end
         default: d = 32'd0;
      endcase
      return d;
   endfunction

   always_comb begin
      w_state          = r_state;
      w_op             = r_op;
      w_a              = r_a;
      w_rt_old         = r_rt_old;
      w_cnt            = r_cnt;
      w_resp_data      = r_resp_data;
      w_resp_err       = r_resp_err;
      w_avm_address    = r_avm_address;
      w_avm_read       = r_avm_read;
      w_avm_write      = r_avm_write;
      w_avm_writedata  = r_avm_writedata;
      w_avm_byteenable = r_avm_byteenable;
      unique case (r_state)
         StIdle, StResp: begin
            w_state = StIdle;
            if (bus_if.req_valid) begin
               w_op     = bus_if.req_op;
               w_a      = bus_if.req_addr[1:0];
               w_rt_old = bus_if.req_rt_old;
               w_cnt    = 32'd0;
               if (f_req_err(bus_if.req_op, bus_if.req_addr[1:0])) begin
                  w_state     = StResp;
                  w_resp_err  = 1'b1;
                  w_resp_data = 32'd0;
               end else begin
                  w_state          = StBus;
                  w_avm_address    = {bus_if.req_addr[ADDR_W-1:2], 2'b00};
                  // Legal reads are ops 0-6 and legal writes 8-10, so bit 3 picks direction.
                  w_avm_read       = ~bus_if.req_op[3];
                  w_avm_write      = bus_if.req_op[3];
                  w_avm_byteenable = f_be(bus_if.req_op, bus_if.req_addr[1:0]);
                  w_avm_writedata  = f_wdata(bus_if.req_op, bus_if.req_wdata);
               end
            end
         end
         StBus: begin
            if (!bus_if.avm_waitrequest) begin
               w_state     = StResp;
               w_avm_read  = 1'b0;
               w_avm_write = 1'b0;
               w_resp_err  = 1'b0;
               w_resp_data = f_load(r_op, r_a, bus_if.avm_readdata, r_rt_old);
            end else if (TIMEOUT != 0 && r_cnt + 32'd1 == TIMEOUT) begin
               w_state     = StResp;
               w_avm_read  = 1'b0;
               w_avm_write = 1'b0;
               w_resp_err  = 1'b1;
               w_resp_data = 32'd0;
            end else begin
               w_cnt = r_cnt + 32'd1;
            end
         end
         default: w_state = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= StIdle;
         r_op             <= 4'd0;
         r_a              <= 2'd0;
         r_rt_old         <= 32'd0;
         r_cnt            <= 32'd0;
         r_resp_data      <= 32'd0;
         r_resp_err       <= 1'b0;
         r_avm_address    <= '0;
         r_avm_read       <= 1'b0;
         r_avm_write      <= 1'b0;
         r_avm_writedata  <= 32'd0;
         r_avm_byteenable <= 4'd0;
      end else begin
         r_state          <= w_state;
         r_op             <= w_op;
         r_a              <= w_a;
         r_rt_old         <= w_rt_old;
         r_cnt            <= w_cnt;
         r_resp_data      <= w_resp_data;
         r_resp_err       <= w_resp_err;
         r_avm_address    <= w_avm_address;
         r_avm_read       <= w_avm_read;
         r_avm_write      <= w_avm_write;
         r_avm_writedata  <= w_avm_writedata;
         r_avm_byteenable <= w_avm_byteenable;
      end
   end

   assign bus_if.req_ready      = (r_state != StBus);
   assign bus_if.resp_valid     = (r_state == StResp);
   assign bus_if.resp_data      = r_resp_data;
   assign bus_if.resp_err       = r_resp_err;
   assign bus_if.avm_address    = r_avm_address;
   assign bus_if.avm_read       = r_avm_read;
   assign bus_if.avm_write      = r_avm_write;
   assign bus_if.avm_writedata  = r_avm_writedata;
   assign bus_if.avm_byteenable = r_avm_byteenable;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu: directed vector table, random vectors against
// an arithmetic reference model, and a reset-during-stall sequence.
module tb_mips_cpu_lsu;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_cpu_lsu_if #(.ADDR_W(AW)) lsu ();

   mips_cpu_lsu #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (lsu)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rt;
      logic [31:0] rdata;
      int unsigned nwait;
      bit          nobus;
      bit          err;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] wd;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, wdata, rt, rdata,
                               input int unsigned nwait, input bit nobus, err,
                               input logic [31:0] data, input logic [3:0] be,
                               input logic [31:0] wd);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rt = rt; v.rdata = rdata;
      v.nwait = nwait; v.nobus = nobus; v.err = err; v.data = data; v.be = be; v.wd = wd;
      return v;
   endfunction

   // Reference: access size decides alignment, lanes and replication; loads via shifts/masks.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int unsigned a, sz;
      bit          legal;
      logic [31:0] rd, b, h, m;
      r = v;
      a = {30'd0, v.addr[1:0]};
      legal = 1'b1;
      sz = 0;
      case (v.op)
         4'd0, 4'd1, 4'd8: sz = 1;
         4'd2, 4'd3, 4'd9: sz = 2;
         4'd4, 4'd10:      sz = 4;
         4'd5, 4'd6:       sz = 0;
         default:          legal = 1'b0;
      endcase
      r.nobus = !legal || (sz != 0 && (a % sz) != 0);
      r.be = (sz == 1) ? 4'(1 << a) : (sz == 2) ? 4'(3 << a) : 4'hF;
      r.wd = (sz == 1) ? (v.wdata & 32'hFF) * 32'h01010101 :
             (sz == 2) ? (v.wdata & 32'hFFFF) * 32'h00010001 : v.wdata;
      rd = v.rdata;
      b = (rd >> (8 * a)) & 32'hFF;
      h = (rd >> (8 * a)) & 32'hFFFF;
      m = (32'h1 << (8 * (3 - a))) - 32'h1;
      case (v.op)
         4'd0:    r.data = b - ((b & 32'h80) << 1);
         4'd1:    r.data = b;
         4'd2:    r.data = h - ((h & 32'h8000) << 1);
         4'd3:    r.data = h;
         4'd4:    r.data = rd;
         4'd5:    r.data = (rd << (8 * (3 - a))) | (v.rt & m);
         4'd6:    r.data = (rd >> (8 * a)) | (v.rt & ~(32'hFFFFFFFF >> (8 * a)));
         default: r.data = 32'd0;
      endcase
      r.err = r.nobus || (v.nwait >= TO);
      if (r.err) r.data = 32'd0;
      return r;
   endfunction

   // Starts at a negedge with the unit ready; ends at the negedge of the response cycle.
   task automatic run_vec(input vec_t v);
      int nbus;
      bit is_wr;
      is_wr = (v.op >= 4'd8);
      if (v.nobus) nbus = 0;
      else if (v.nwait >= TO) nbus = int'(TO);
      else nbus = int'(v.nwait) + 1;
      chk("req_ready_idle", lsu.req_ready, 1);
      lsu.req_valid  = 1'b1;
      lsu.req_op     = v.op;
      lsu.req_addr   = v.addr;
      lsu.req_wdata  = v.wdata;
      lsu.req_rt_old = v.rt;
      @(posedge clk);
      @(negedge clk);
      lsu.req_valid  = 1'b0;
      lsu.req_op     = 4'($urandom);
      lsu.req_addr   = $urandom;
      lsu.req_wdata  = $urandom;
      lsu.req_rt_old = $urandom;
      for (int k = 0; k < nbus; k++) begin
         chk("avm_read", lsu.avm_read, !is_wr);
         chk("avm_write", lsu.avm_write, is_wr);
         chk("avm_address", lsu.avm_address, {v.addr[31:2], 2'b00});
         chk("avm_byteenable", lsu.avm_byteenable, v.be);
         if (is_wr) chk("avm_writedata", lsu.avm_writedata, v.wd);
         chk("req_ready_bus", lsu.req_ready, 0);
         chk("resp_valid_bus", lsu.resp_valid, 0);
         lsu.avm_waitrequest = (k < int'(v.nwait));
         lsu.avm_readdata    = (k == int'(v.nwait)) ? v.rdata : $urandom;
         @(negedge clk);
      end
      lsu.avm_waitrequest = 1'($urandom);
      lsu.avm_readdata    = $urandom;
      chk("resp_valid", lsu.resp_valid, 1);
      chk("resp_err", lsu.resp_err, v.err);
      chk("resp_data", lsu.resp_data, v.data);
      chk("avm_read_resp", lsu.avm_read, 0);
      chk("avm_write_resp", lsu.avm_write, 0);
      chk("req_ready_resp", lsu.req_ready, 1);
   endtask

   task automatic idle_cycle(input vec_t last);
      @(negedge clk);
      chk("resp_valid_pulse", lsu.resp_valid, 0);
      chk("resp_data_held", lsu.resp_data, last.data);
      chk("resp_err_held", lsu.resp_err, last.err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [3:0] ops [12];
      lsu.req_valid = 1'b0; lsu.req_op = 4'd0; lsu.req_addr = '0; lsu.req_wdata = '0;
      lsu.req_rt_old = '0; lsu.avm_waitrequest = 1'b0; lsu.avm_readdata = '0;

      // Directed vectors; entry 7 (timeout) is followed back-to-back by entry 8.
      tbl.push_back(mk(4'd10, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 4'hF, 32'hDEADBEEF));
      tbl.push_back(mk(4'd0, 32'h1003, 0, 0, 32'h80FFFF12, 3, 0, 0, 32'hFFFFFF80, 4'h8, 0));
      tbl.push_back(mk(4'd1, 32'h1003, 0, 0, 32'h80FFFF12, 0, 0, 0, 32'h00000080, 4'h8, 0));
      tbl.push_back(mk(4'd9, 32'h2002, 32'h0000ABCD, 0, 0, 0, 0, 0, 32'h0, 4'hC, 32'hABCDABCD));
      tbl.push_back(mk(4'd2, 32'h2001, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd5, 32'h11, 0, 32'h11223344, 32'hAABBCCDD, 1, 0, 0, 32'hCCDD3344, 4'hF, 0));
      tbl.push_back(mk(4'd6, 32'h11, 0, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 32'h11AABBCC, 4'hF, 0));
      tbl.push_back(mk(4'd4, 32'h4, 0, 0, 32'h12345678, 10, 0, 1, 32'h0, 4'hF, 0));
      tbl.push_back(mk(4'd8, 32'h1001, 32'h123456A5, 0, 0, 2, 0, 0, 32'h0, 4'h2, 32'hA5A5A5A5));
      tbl.push_back(mk(4'd7, 32'h0, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd4, 32'h1002, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd3, 32'h2002, 0, 0, 32'h80017FFE, 1, 0, 0, 32'h00008001, 4'hC, 0));
      tbl.push_back(mk(4'd2, 32'h2000, 0, 0, 32'h80017FFE, 0, 0, 0, 32'h00007FFE, 4'h3, 0));
      tbl.push_back(mk(4'd2, 32'h2002, 0, 0, 32'h80017FFE, 2, 0, 0, 32'hFFFF8001, 4'hC, 0));
      tbl.push_back(mk(4'd5, 32'h13, 0, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 32'hAABBCCDD, 4'hF, 0));
      tbl.push_back(mk(4'd6, 32'h10, 0, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 32'hAABBCCDD, 4'hF, 0));
      tbl.push_back(mk(4'd11, 32'h0, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd10, 32'h1001, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd9, 32'h2003, 0, 0, 0, 0, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd10, 32'hFFFFFFFE, 32'h01234567, 0, 0, 7, 1, 1, 32'h0, 4'h0, 0));
      tbl.push_back(mk(4'd10, 32'hFFFFFFFC, 32'h01234567, 0, 0, 7, 0, 0, 32'h0, 4'hF, 32'h01234567));
      tbl.push_back(mk(4'd4, 32'h8, 0, 0, 32'hCAFEF00D, 8, 0, 1, 32'h0, 4'hF, 0));
      tbl.push_back(mk(4'd4, 32'h8, 0, 0, 32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D, 4'hF, 0));

      @(negedge clk);
      @(negedge clk);
      chk("rst_req_ready", lsu.req_ready, 1);
      chk("rst_resp_valid", lsu.resp_valid, 0);
      chk("rst_resp_err", lsu.resp_err, 0);
      chk("rst_resp_data", lsu.resp_data, 0);
      chk("rst_avm_read", lsu.avm_read, 0);
      chk("rst_avm_write", lsu.avm_write, 0);
      chk("rst_avm_address", lsu.avm_address, 0);
      chk("rst_avm_byteenable", lsu.avm_byteenable, 0);
      chk("rst_avm_writedata", lsu.avm_writedata, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i]);
         if (i % 3 == 2) idle_cycle(tbl[i]);
      end

      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd7, 4'd13};
      for (int i = 0; i < 80; i++) begin
         v.op    = ops[$urandom_range(0, 11)];
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.rt    = $urandom;
         v.rdata = $urandom;
         v.nwait = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
         v = model(v);
         run_vec(v);
         if ($urandom_range(0, 1) == 1) idle_cycle(v);
      end

      // Reset while the bus is stalled: no response, bus released next cycle.
      lsu.req_valid = 1'b1;
      lsu.req_op    = 4'd4;
      lsu.req_addr  = 32'h100;
      @(posedge clk);
      @(negedge clk);
      lsu.req_valid = 1'b0;
      chk("mid_avm_read", lsu.avm_read, 1);
      lsu.avm_waitrequest = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_avm_read", lsu.avm_read, 0);
      chk("mid_rst_avm_write", lsu.avm_write, 0);
      chk("mid_rst_req_ready", lsu.req_ready, 1);
      chk("mid_rst_resp_valid", lsu.resp_valid, 0);
      chk("mid_rst_resp_data", lsu.resp_data, 0);
      chk("mid_rst_avm_address", lsu.avm_address, 0);
      rst = 1'b0;
      lsu.avm_waitrequest = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_resp_valid", lsu.resp_valid, 0);
         chk("post_rst_avm_read", lsu.avm_read, 0);
      end
      run_vec(tbl[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
